// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and defaults for the display scroll sequencer
package display_pkg;

  typedef enum logic [1:0] {IDLE, SAVE, SHIFT, WAIT} scroll_state_t;

  localparam int DEF_NO_LED = 8;
  localparam int DEF_DIV_W  = 24;

  function automatic int pos_width(input int n_led);
    return (n_led > 1) ? $clog2(n_led) : 1;
  endfunction

endpackage

// File: rtl/display_scroll_ctrl_if.sv
// rtl/display_scroll_ctrl_if.sv - control/status bundle between register block and scroll sequencer
interface display_scroll_ctrl_if
  import display_pkg::*;
#(
  parameter int pNO_LED = DEF_NO_LED,
  parameter int pDIV_W  = DEF_DIV_W
) ();

  localparam int POS_W = pos_width(pNO_LED);

  logic              start;
  logic              stop;
  logic              step;
  logic [pDIV_W-1:0] div_val;
  logic              save;
  logic              en;
  logic              busy;
  logic [POS_W-1:0]  pos;
  logic              wrap;

  modport master (
    output start, stop, step, div_val,
    input  save, en, busy, pos, wrap
  );

  modport slave (
    input  start, stop, step, div_val,
    output save, en, busy, pos, wrap
  );

endinterface

// File: rtl/scroll_prescaler.sv
// rtl/scroll_prescaler.sv - loadable down-counter timing the gap between scroll steps
module scroll_prescaler #(
  parameter int pDIV_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [pDIV_W-1:0] load_val_i,
  input  logic              dec_i,
  output logic              zero_o
);

  logic [pDIV_W-1:0] cnt_q;
  logic [pDIV_W-1:0] cnt_d;

  // Saturates at zero so a stray dec can never wrap to the maximum count.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - pDIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/display_scroll_ctrl.sv
// rtl/display_scroll_ctrl.sv - save/en sequencer rotating an 8-digit shift-register display left
module display_scroll_ctrl
  import display_pkg::*;
#(
  parameter int pNO_LED = DEF_NO_LED,
  parameter int pDIV_W  = DEF_DIV_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  display_scroll_ctrl_if.slave bus
);

  localparam int               POS_W   = pos_width(pNO_LED);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(pNO_LED - 1);

  scroll_state_t    state_q, state_d;
  logic             run_q, run_d;
  logic             stop_pend_q, stop_pend_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             wrap_q, wrap_d;
  logic             save_q, en_q, busy_q;
  logic             cnt_load, cnt_dec, cnt_zero;

  scroll_prescaler #(
    .pDIV_W (pDIV_W)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (bus.div_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Outputs are derived from state_d and registered, so they line up with state_q.
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    stop_pend_d = stop_pend_q;
    pos_d       = pos_q;
    wrap_d      = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bus.stop) begin
          if (bus.start) begin
            run_d   = 1'b1;
            state_d = SAVE;
          end else if (bus.step) begin
            run_d   = 1'b0;
            state_d = SAVE;
          end
        end
      end

      SAVE: begin
        // Once save has fired the en must follow; a stop here only ends the run afterwards.
        if (bus.stop) begin
          stop_pend_d = 1'b1;
        end
        state_d = SHIFT;
        wrap_d  = (pos_q == POS_MAX);
        pos_d   = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
      end

      SHIFT: begin
        if (run_q && !stop_pend_q && !bus.stop) begin
          state_d  = WAIT;
          cnt_load = 1'b1;
        end else begin
          state_d     = IDLE;
          run_d       = 1'b0;
          stop_pend_d = 1'b0;
        end
      end

      WAIT: begin
        if (bus.stop) begin
          state_d = IDLE;
          run_d   = 1'b0;
        end else if (cnt_zero) begin
          state_d = SAVE;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        run_d       = 1'b0;
        stop_pend_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      run_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      pos_q       <= '0;
      wrap_q      <= 1'b0;
      save_q      <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      stop_pend_q <= stop_pend_d;
      pos_q       <= pos_d;
      wrap_q      <= wrap_d;
      save_q      <= (state_d == SAVE);
      en_q        <= (state_d == SHIFT);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.save = save_q;
  assign bus.en   = en_q;
  assign bus.busy = busy_q;
  assign bus.pos  = pos_q;
  assign bus.wrap = wrap_q;

endmodule
